operand_fetch_stage: RTL

- Decode-side operand stage; sits directly upstream of regfile read ports and downstream of instruction decode.
- Drives the two regfile read ports and resolves RAW hazards by forwarding from EX/MEM/WB.
- Detects load-use hazards and stalls decode for them.
- Registers resolved operands plus control into the ID/EX pipeline register, with valid/ready handshakes on both sides.

---
 rtl/operand_fetch_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode-side operand fetch with EX/MEM/WB forwarding and load-use stall
//
// Reads two source operands from the register file and substitutes newer values
// that are still in flight in EX, MEM or WB. A load in EX whose result is needed
// now stalls decode for that cycle. The resolved operands and pass-through fields
// are held in the ID/EX register, with valid/ready handshakes on both sides.
//
// Optional feature macro: OPFETCH_PERF_EN (adds the perf_stall_cnt output).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            drop the held instruction, block capture
//   in_valid / in_ready              decode-side handshake
//   in_src_ena, in_src_addr          per-source use flags and register addresses
//   in_rd_we, in_rd_addr, in_pc,
//   in_ctrl                          fields passed through to EX
//   rf_read_ena, rf_read_addr        register file read port drive
//   rf_read_data                     register file read data (combinational)
//   ex_*, mem_*, wb_*                forwarding sources (EX data invalid for loads)
//   out_valid / out_ready            EX-side handshake
//   out_src_data, out_rd_we,
//   out_rd_addr, out_pc, out_ctrl    ID/EX register contents
//   perf_stall_cnt                   saturating load-use stall count (optional)

module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_src_ena,
    input  logic [1:0][ADDR_W-1:0]       in_src_addr,
    input  logic                         in_rd_we,
    input  logic [ADDR_W-1:0]            in_rd_addr,
    input  logic [31:0]                  in_pc,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic [1:0]                   rf_read_ena,
    output logic [1:0][ADDR_W-1:0]       rf_read_addr,
    input  logic [1:0][DATA_W-1:0]       rf_read_data,
    input  logic                         ex_wr_ena,
    input  logic [ADDR_W-1:0]            ex_wr_addr,
    input  logic [DATA_W-1:0]            ex_wr_data,
    input  logic                         ex_is_load,
    input  logic                         mem_wr_ena,
    input  logic [ADDR_W-1:0]            mem_wr_addr,
    input  logic [DATA_W-1:0]            mem_wr_data,
    input  logic                         wb_wr_ena,
    input  logic [ADDR_W-1:0]            wb_wr_addr,
    input  logic [DATA_W-1:0]            wb_wr_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0][DATA_W-1:0]       out_src_data,
    output logic                         out_rd_we,
    output logic [ADDR_W-1:0]            out_rd_addr,
    output logic [31:0]                  out_pc,
    output logic [CTRL_W-1:0]            out_ctrl
`ifdef OPFETCH_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    logic [1:0][DATA_W-1:0] src_val;
    logic [1:0]             load_hit;
    logic                   hazard;
    logic                   capture;

    logic                   out_valid_q, out_valid_d;
    logic [1:0][DATA_W-1:0] src_data_q;
    logic                   rd_we_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic [31:0]            pc_q;
    logic [CTRL_W-1:0]      ctrl_q;

    assign rf_read_ena  = in_src_ena;
    assign rf_read_addr = in_src_addr;

    // Youngest producer wins. r0 is hardwired zero and never forwarded. A hit on
    // a load in EX marks the source as not yet available.
    always_comb begin
        src_val  = '0;
        load_hit = '0;
        for (int i = 0; i < 2; i++) begin
            if (!in_src_ena[i] || (in_src_addr[i] == '0)) begin
                src_val[i] = '0;
            end else if (ex_wr_ena && (in_src_addr[i] == ex_wr_addr)) begin
                src_val[i]  = ex_wr_data;
                load_hit[i] = ex_is_load;
            end else if (mem_wr_ena && (in_src_addr[i] == mem_wr_addr)) begin
                src_val[i] = mem_wr_data;
            end else if (wb_wr_ena && (in_src_addr[i] == wb_wr_addr)) begin
                // The regfile write only lands at the next posedge.
                src_val[i] = wb_wr_data;
            end else begin
                src_val[i] = rf_read_data[i];
            end
        end
    end

    assign hazard   = in_valid && (|load_hit);
    assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            src_data_q  <= '0;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            pc_q        <= '0;
            ctrl_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            // capture already excludes flush, so a flushed cycle holds the data.
            if (capture) begin
                src_data_q <= src_val;
                rd_we_q    <= in_rd_we;
                rd_addr_q  <= in_rd_addr;
                pc_q       <= in_pc;
                ctrl_q     <= in_ctrl;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_src_data = src_data_q;
    assign out_rd_we    = rd_we_q;
    assign out_rd_addr  = rd_addr_q;
    assign out_pc       = pc_q;
    assign out_ctrl     = ctrl_q;

`ifdef OPFETCH_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
